// File: rtl/mdu_ctrl_if.sv
// mdu_ctrl_if: EX-side request, writeback response and flush bundle of the M-extension sequencer
interface mdu_ctrl_if #(parameter int XLEN = 32);
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_funct3;
    logic            req_word;
    logic [XLEN-1:0] req_rs1;
    logic [XLEN-1:0] req_rs2;
    logic [4:0]      req_rd;
    logic            flush;
    logic            busy;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_data;
    logic [4:0]      resp_rd;

    modport master (
        output req_valid, req_funct3, req_word, req_rs1, req_rs2, req_rd, flush, resp_ready,
        input  req_ready, busy, resp_valid, resp_data, resp_rd
    );

    modport slave (
        input  req_valid, req_funct3, req_word, req_rs1, req_rs2, req_rd, flush, resp_ready,
        output req_ready, busy, resp_valid, resp_data, resp_rd
    );
endinterface

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: M-extension sequencer with internal multiplier and external iterative divider launch
module mdu_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    mdu_ctrl_if.slave       bus,
    output logic            div_start,
    output logic [1:0]      div_op,
    output logic            div_word,
    output logic [XLEN-1:0] div_dividend,
    output logic [XLEN-1:0] div_divisor,
    input  logic [XLEN-1:0] div_result,
    input  logic            div_busy,
    input  logic            div_ready
);
    typedef enum logic [2:0] {IDLE, MUL, DIV_ISSUE, DIV_WAIT, DRAIN, RESP} state_t;

    state_t            state, state_nxt;
    logic [XLEN-1:0]   a_q, b_q, a_in, b_in, resp_data_q;
    logic [1:0]        op_q;
    logic              word_q;
    logic [4:0]        rd_q;
    logic              accept, sa, sb;
    logic [2*XLEN-1:0] ea, eb, prod;
    logic [XLEN-1:0]   mul_raw, mul_res, div_res;

    assign accept = bus.req_valid && bus.req_ready;

    // Signed (XLEN+1)x(XLEN+1) product; MULHU is the only op with unsigned rs1, MUL/MULH the only ones with signed rs2
    assign sa      = op_q != 2'b11;
    assign sb      = !op_q[1];
    assign ea      = {{XLEN{sa & a_q[XLEN-1]}}, a_q};
    assign eb      = {{XLEN{sb & b_q[XLEN-1]}}, b_q};
    assign prod    = ea * eb;
    assign mul_raw = (op_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    generate
        if (XLEN == 64) begin : g_rv64
            logic op_signed;
            // DIVUW/REMUW zero-extend their operands; every other W op sign-extends
            assign op_signed = !(bus.req_funct3[2] && bus.req_funct3[0]);
            assign a_in    = bus.req_word ? {{(XLEN-32){op_signed & bus.req_rs1[31]}}, bus.req_rs1[31:0]} : bus.req_rs1;
            assign b_in    = bus.req_word ? {{(XLEN-32){op_signed & bus.req_rs2[31]}}, bus.req_rs2[31:0]} : bus.req_rs2;
            // W results are re-extended here so a divider that leaves upper bits dirty cannot leak them
            assign mul_res = word_q ? {{(XLEN-32){mul_raw[31]}}, mul_raw[31:0]} : mul_raw;
            assign div_res = word_q ? {{(XLEN-32){div_result[31]}}, div_result[31:0]} : div_result;
        end else begin : g_rv32
            assign a_in    = bus.req_rs1;
            assign b_in    = bus.req_rs2;
            assign mul_res = mul_raw;
            assign div_res = div_result;
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state: flush in DIV_WAIT must still drain the divider unless its result lands in the same cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (accept) state_nxt = bus.req_funct3[2] ? DIV_ISSUE : MUL;
            MUL:       state_nxt = bus.flush ? IDLE : RESP;
            DIV_ISSUE: state_nxt = bus.flush ? IDLE : (div_busy ? DIV_ISSUE : DIV_WAIT);
            DIV_WAIT:  state_nxt = bus.flush ? (div_ready ? IDLE : DRAIN) : (div_ready ? RESP : DIV_WAIT);
            DRAIN:     state_nxt = div_ready ? IDLE : DRAIN;
            RESP:      state_nxt = (bus.resp_ready || bus.flush) ? IDLE : RESP;
            default:   state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state; div_start never fires into a busy divider or a flushed op
    always_comb begin
        bus.req_ready  = (state == IDLE) && !bus.flush;
        bus.busy       = state != IDLE;
        bus.resp_valid = state == RESP;
        div_start      = (state == DIV_ISSUE) && !div_busy && !bus.flush;
    end

    // Operand/tag capture on accept and result capture; operands stay put until the next accept
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            word_q      <= 1'b0;
            rd_q        <= '0;
            resp_data_q <= '0;
        end else begin
            if (accept) begin
                a_q    <= a_in;
                b_q    <= b_in;
                op_q   <= bus.req_funct3[1:0];
                word_q <= bus.req_word;
                rd_q   <= bus.req_rd;
            end
            if (state == MUL && !bus.flush)
                resp_data_q <= mul_res;
            if (state == DIV_WAIT && div_ready && !bus.flush)
                resp_data_q <= div_res;
        end
    end

    assign bus.resp_data = resp_data_q;
    assign bus.resp_rd   = rd_q;
    assign div_dividend  = a_q;
    assign div_divisor   = b_q;
    assign div_op        = op_q;
    assign div_word      = word_q;
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed bench for mdu_ctrl at XLEN=32 and XLEN=64, acting as the divider
module tb_mdu_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mdu_ctrl_if #(.XLEN(32)) bus32();
    mdu_ctrl_if #(.XLEN(64)) bus64();

    logic        d32_start, d32_word, d32_busy, d32_rdy;
    logic [1:0]  d32_op;
    logic [31:0] d32_dvd, d32_dvs, d32_res;
    logic        d64_start, d64_word, d64_busy, d64_rdy;
    logic [1:0]  d64_op;
    logic [63:0] d64_dvd, d64_dvs, d64_res;

    mdu_ctrl #(.XLEN(32)) u32 (
        .clk(clk), .reset(reset), .bus(bus32),
        .div_start(d32_start), .div_op(d32_op), .div_word(d32_word),
        .div_dividend(d32_dvd), .div_divisor(d32_dvs),
        .div_result(d32_res), .div_busy(d32_busy), .div_ready(d32_rdy)
    );

    mdu_ctrl #(.XLEN(64)) u64 (
        .clk(clk), .reset(reset), .bus(bus64),
        .div_start(d64_start), .div_op(d64_op), .div_word(d64_word),
        .div_dividend(d64_dvd), .div_divisor(d64_dvs),
        .div_result(d64_res), .div_busy(d64_busy), .div_ready(d64_rdy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic req32(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        bus32.req_valid  = 1'b1;
        bus32.req_funct3 = f3;
        bus32.req_word   = 1'b0;
        bus32.req_rs1    = a;
        bus32.req_rs2    = b;
        bus32.req_rd     = rd;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) tick;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus32.req_ready !== 1'b1 || bus32.busy !== 1'b0 || bus32.resp_valid !== 1'b0 ||
            bus32.resp_data !== 32'd0 || bus32.resp_rd !== 5'd0 || d32_start !== 1'b0 ||
            d32_op !== 2'd0 || d32_word !== 1'b0 || d32_dvd !== 32'd0 || d32_dvs !== 32'd0) begin
            failures++;
            $display("FAIL reset32: rdy=%b busy=%b rv=%b data=%h rd=%0d start=%b op=%0d word=%b dvd=%h dvs=%h, expected rdy=1 rest 0",
                     bus32.req_ready, bus32.busy, bus32.resp_valid, bus32.resp_data, bus32.resp_rd,
                     d32_start, d32_op, d32_word, d32_dvd, d32_dvs);
        end
        checks++;
        if (bus64.req_ready !== 1'b1 || bus64.busy !== 1'b0 || bus64.resp_data !== 64'd0 || d64_dvd !== 64'd0) begin
            failures++;
            $display("FAIL reset64: rdy=%b busy=%b data=%h dvd=%h, expected rdy=1 rest 0",
                     bus64.req_ready, bus64.busy, bus64.resp_data, d64_dvd);
        end
    endtask

    task automatic mul32(input string nm, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp);
        tick;
        req32(f3, a, b, rd);
        @(negedge clk);
        checks++;
        if (bus32.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s accept: req_ready=%b, expected 1", nm, bus32.req_ready);
        end
        tick;
        bus32.req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus32.resp_valid !== 1'b0 || bus32.busy !== 1'b1) begin
            failures++;
            $display("FAIL %s cycle1: resp_valid=%b busy=%b, expected 0 1", nm, bus32.resp_valid, bus32.busy);
        end
        tick;
        @(negedge clk);
        checks++;
        if (bus32.resp_valid !== 1'b1 || bus32.resp_data !== exp || bus32.resp_rd !== rd) begin
            failures++;
            $display("FAIL %s result: valid=%b data=%h rd=%0d, expected 1 %h %0d",
                     nm, bus32.resp_valid, bus32.resp_data, bus32.resp_rd, exp, rd);
        end
        bus32.resp_ready = 1'b1;
        tick;
        bus32.resp_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (bus32.busy !== 1'b0 || bus32.resp_valid !== 1'b0 || bus32.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s idle: busy=%b resp_valid=%b req_ready=%b, expected 0 0 1",
                     nm, bus32.busy, bus32.resp_valid, bus32.req_ready);
        end
    endtask

    task automatic div32(input string nm, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] res, input logic [31:0] exp, input int lat);
        tick;
        req32(f3, a, b, rd);
        @(negedge clk);
        checks++;
        if (bus32.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s accept: req_ready=%b, expected 1", nm, bus32.req_ready);
        end
        tick;
        bus32.req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (d32_start !== 1'b1 || d32_dvd !== a || d32_dvs !== b || d32_op !== f3[1:0]) begin
            failures++;
            $display("FAIL %s launch: start=%b dvd=%h dvs=%h op=%0d, expected 1 %h %h %0d",
                     nm, d32_start, d32_dvd, d32_dvs, d32_op, a, b, f3[1:0]);
        end
        tick;
        d32_busy = 1'b1;
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            checks++;
            if (d32_start !== 1'b0 || d32_dvd !== a || d32_dvs !== b || d32_op !== f3[1:0] || bus32.resp_valid !== 1'b0) begin
                failures++;
                $display("FAIL %s wait%0d: start=%b dvd=%h dvs=%h op=%0d rv=%b, expected 0 %h %h %0d 0",
                         nm, i, d32_start, d32_dvd, d32_dvs, d32_op, bus32.resp_valid, a, b, f3[1:0]);
            end
            if (i == lat - 1) begin
                d32_rdy = 1'b1;
                d32_res = res;
            end
            tick;
        end
        d32_rdy  = 1'b0;
        d32_busy = 1'b0;
        d32_res  = 32'h0;
        @(negedge clk);
        checks++;
        if (bus32.resp_valid !== 1'b1 || bus32.resp_data !== exp || bus32.resp_rd !== rd) begin
            failures++;
            $display("FAIL %s result: valid=%b data=%h rd=%0d, expected 1 %h %0d",
                     nm, bus32.resp_valid, bus32.resp_data, bus32.resp_rd, exp, rd);
        end
        bus32.resp_ready = 1'b1;
        tick;
        bus32.resp_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (bus32.busy !== 1'b0) begin
            failures++;
            $display("FAIL %s idle: busy=%b, expected 0", nm, bus32.busy);
        end
    endtask

    task automatic test_mul;
        mul32("mul_7x-3", 3'b000, 32'd7, 32'hFFFFFFFD, 5'd1, 32'hFFFFFFEB);
        mul32("mulhu_max", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'hFFFFFFFE);
        mul32("mulhsu_-1", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'hFFFFFFFF);
        mul32("mulh_-1x-1", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 32'h00000000);
        mul32("mulh_min", 3'b001, 32'h80000000, 32'h80000000, 5'd5, 32'h40000000);
    endtask

    task automatic test_div;
        div32("div_-20/3", 3'b100, 32'hFFFFFFEC, 32'd3, 5'd6, 32'hFFFFFFFA, 32'hFFFFFFFA, 3);
        div32("rem_-20/3", 3'b110, 32'hFFFFFFEC, 32'd3, 5'd7, 32'hFFFFFFFE, 32'hFFFFFFFE, 1);
        div32("divu_20/0", 3'b101, 32'd20, 32'd0, 5'd8, 32'hFFFFFFFF, 32'hFFFFFFFF, 2);
        div32("rem_20/0", 3'b110, 32'd20, 32'd0, 5'd9, 32'd20, 32'd20, 4);
    endtask

    task automatic test_div_busy_hold;
        d32_busy = 1'b1;
        tick;
        req32(3'b111, 32'd17, 32'd5, 5'd10);
        @(negedge clk);
        tick;
        bus32.req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (d32_start !== 1'b0 || bus32.busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_hold0: start=%b busy=%b, expected 0 1", d32_start, bus32.busy);
        end
        tick;
        @(negedge clk);
        checks++;
        if (d32_start !== 1'b0) begin
            failures++;
            $display("FAIL busy_hold1: start=%b, expected 0", d32_start);
        end
        tick;
        d32_busy = 1'b0;
        @(negedge clk);
        checks++;
        if (d32_start !== 1'b1 || d32_op !== 2'b11) begin
            failures++;
            $display("FAIL busy_release: start=%b op=%0d, expected 1 3", d32_start, d32_op);
        end
        tick;
        d32_busy = 1'b1;
        @(negedge clk);
        checks++;
        if (d32_start !== 1'b0) begin
            failures++;
            $display("FAIL busy_single: start=%b, expected 0", d32_start);
        end
        d32_rdy = 1'b1;
        d32_res = 32'd2;
        tick;
        d32_rdy  = 1'b0;
        d32_busy = 1'b0;
        @(negedge clk);
        checks++;
        if (bus32.resp_valid !== 1'b1 || bus32.resp_data !== 32'd2 || bus32.resp_rd !== 5'd10) begin
            failures++;
            $display("FAIL busy_result: valid=%b data=%h rd=%0d, expected 1 2 10",
                     bus32.resp_valid, bus32.resp_data, bus32.resp_rd);
        end
        bus32.resp_ready = 1'b1;
        tick;
        bus32.resp_ready = 1'b0;
    endtask

    task automatic test_flush_issue;
        tick;
        req32(3'b100, 32'd9, 32'd3, 5'd11);
        @(negedge clk);
        tick;
        bus32.req_valid = 1'b0;
        bus32.flush     = 1'b1;
        @(negedge clk);
        checks++;
        if (d32_start !== 1'b0) begin
            failures++;
            $display("FAIL flush_issue: start=%b, expected 0", d32_start);
        end
        tick;
        bus32.flush = 1'b0;
        @(negedge clk);
        checks++;
        if (bus32.busy !== 1'b0 || d32_start !== 1'b0 || bus32.resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_issue_idle: busy=%b start=%b rv=%b, expected 0 0 0",
                     bus32.busy, d32_start, bus32.resp_valid);
        end
    endtask

    task automatic test_flush_drain;
        tick;
        req32(3'b100, 32'd100, 32'd7, 5'd3);
        @(negedge clk);
        tick;
        bus32.req_valid = 1'b0;
        @(negedge clk);
        tick;
        d32_busy = 1'b1;
        @(negedge clk);
        tick;
        bus32.flush = 1'b1;
        req32(3'b100, 32'hFFFFFFEC, 32'd3, 5'd9);
        @(negedge clk);
        tick;
        bus32.flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus32.req_ready !== 1'b0 || bus32.resp_valid !== 1'b0 || d32_start !== 1'b0 || bus32.busy !== 1'b1) begin
                failures++;
                $display("FAIL drain%0d: req_ready=%b rv=%b start=%b busy=%b, expected 0 0 0 1",
                         i, bus32.req_ready, bus32.resp_valid, d32_start, bus32.busy);
            end
            tick;
        end
        @(negedge clk);
        d32_rdy = 1'b1;
        d32_res = 32'hDEADBEEF;
        checks++;
        if (bus32.req_ready !== 1'b0) begin
            failures++;
            $display("FAIL drain_last: req_ready=%b, expected 0", bus32.req_ready);
        end
        tick;
        d32_rdy  = 1'b0;
        d32_busy = 1'b0;
        d32_res  = 32'h0;
        @(negedge clk);
        checks++;
        if (bus32.req_ready !== 1'b1 || bus32.resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL drain_done: req_ready=%b rv=%b, expected 1 0", bus32.req_ready, bus32.resp_valid);
        end
        tick;
        bus32.req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (d32_start !== 1'b1 || d32_dvd !== 32'hFFFFFFEC || d32_dvs !== 32'd3 || bus32.resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL post_drain_launch: start=%b dvd=%h dvs=%h rv=%b, expected 1 ffffffec 3 0",
                     d32_start, d32_dvd, d32_dvs, bus32.resp_valid);
        end
        tick;
        d32_busy = 1'b1;
        @(negedge clk);
        d32_rdy = 1'b1;
        d32_res = 32'hFFFFFFFA;
        tick;
        d32_rdy  = 1'b0;
        d32_busy = 1'b0;
        @(negedge clk);
        checks++;
        if (bus32.resp_valid !== 1'b1 || bus32.resp_data !== 32'hFFFFFFFA || bus32.resp_rd !== 5'd9) begin
            failures++;
            $display("FAIL post_drain_result: valid=%b data=%h rd=%0d, expected 1 fffffffa 9",
                     bus32.resp_valid, bus32.resp_data, bus32.resp_rd);
        end
        bus32.resp_ready = 1'b1;
        tick;
        bus32.resp_ready = 1'b0;
    endtask

    task automatic test_resp_hold;
        tick;
        req32(3'b000, 32'd6, 32'd7, 5'd12);
        @(negedge clk);
        tick;
        bus32.req_valid = 1'b0;
        tick;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus32.resp_valid !== 1'b1 || bus32.resp_data !== 32'd42 || bus32.resp_rd !== 5'd12) begin
                failures++;
                $display("FAIL hold%0d: valid=%b data=%h rd=%0d, expected 1 2a 12",
                         i, bus32.resp_valid, bus32.resp_data, bus32.resp_rd);
            end
            tick;
        end
        @(negedge clk);
        bus32.flush      = 1'b1;
        bus32.resp_ready = 1'b1;
        #1;
        checks++;
        if (bus32.resp_valid !== 1'b1 || bus32.resp_data !== 32'd42) begin
            failures++;
            $display("FAIL flush_with_ready: valid=%b data=%h, expected 1 2a", bus32.resp_valid, bus32.resp_data);
        end
        tick;
        bus32.flush      = 1'b0;
        bus32.resp_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (bus32.busy !== 1'b0 || bus32.resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_with_ready_idle: busy=%b rv=%b, expected 0 0", bus32.busy, bus32.resp_valid);
        end
        tick;
        req32(3'b000, 32'd2, 32'd3, 5'd13);
        @(negedge clk);
        tick;
        bus32.req_valid = 1'b0;
        tick;
        @(negedge clk);
        bus32.flush = 1'b1;
        tick;
        bus32.flush = 1'b0;
        @(negedge clk);
        checks++;
        if (bus32.busy !== 1'b0 || bus32.resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_resp_discard: busy=%b rv=%b, expected 0 0", bus32.busy, bus32.resp_valid);
        end
    endtask

    task automatic test_reset_mid_div;
        tick;
        req32(3'b101, 32'd50, 32'd5, 5'd14);
        @(negedge clk);
        tick;
        bus32.req_valid = 1'b0;
        @(negedge clk);
        tick;
        d32_busy = 1'b1;
        @(negedge clk);
        tick;
        reset    = 1'b1;
        d32_busy = 1'b0;
        tick;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus32.req_ready !== 1'b1 || bus32.busy !== 1'b0 || bus32.resp_valid !== 1'b0 ||
            bus32.resp_data !== 32'd0 || bus32.resp_rd !== 5'd0 || d32_start !== 1'b0 ||
            d32_op !== 2'd0 || d32_word !== 1'b0 || d32_dvd !== 32'd0 || d32_dvs !== 32'd0) begin
            failures++;
            $display("FAIL reset_mid_div: rdy=%b busy=%b rv=%b data=%h rd=%0d start=%b op=%0d word=%b dvd=%h dvs=%h, expected rdy=1 rest 0",
                     bus32.req_ready, bus32.busy, bus32.resp_valid, bus32.resp_data, bus32.resp_rd,
                     d32_start, d32_op, d32_word, d32_dvd, d32_dvs);
        end
        mul32("mul_after_reset", 3'b000, 32'd3, 32'd5, 5'd15, 32'd15);
    endtask

    task automatic div64(input string nm, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] edvd, input logic [63:0] edvs, input logic [63:0] res, input logic [63:0] exp);
        tick;
        bus64.req_valid  = 1'b1;
        bus64.req_funct3 = f3;
        bus64.req_word   = 1'b1;
        bus64.req_rs1    = a;
        bus64.req_rs2    = b;
        bus64.req_rd     = 5'd20;
        @(negedge clk);
        tick;
        bus64.req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (d64_start !== 1'b1 || d64_dvd !== edvd || d64_dvs !== edvs || d64_word !== 1'b1 || d64_op !== f3[1:0]) begin
            failures++;
            $display("FAIL %s launch: start=%b dvd=%h dvs=%h word=%b op=%0d, expected 1 %h %h 1 %0d",
                     nm, d64_start, d64_dvd, d64_dvs, d64_word, d64_op, edvd, edvs, f3[1:0]);
        end
        tick;
        d64_busy = 1'b1;
        @(negedge clk);
        d64_rdy = 1'b1;
        d64_res = res;
        tick;
        d64_rdy  = 1'b0;
        d64_busy = 1'b0;
        @(negedge clk);
        checks++;
        if (bus64.resp_valid !== 1'b1 || bus64.resp_data !== exp || bus64.resp_rd !== 5'd20) begin
            failures++;
            $display("FAIL %s result: valid=%b data=%h rd=%0d, expected 1 %h 20",
                     nm, bus64.resp_valid, bus64.resp_data, bus64.resp_rd, exp);
        end
        bus64.resp_ready = 1'b1;
        tick;
        bus64.resp_ready = 1'b0;
    endtask

    task automatic test_w_ops;
        div64("divw_min/-1", 3'b100, 64'h00000000_80000000, 64'hFFFFFFFF_FFFFFFFF,
              64'hFFFFFFFF_80000000, 64'hFFFFFFFF_FFFFFFFF, 64'h00000000_80000000, 64'hFFFFFFFF_80000000);
        div64("divuw", 3'b101, 64'hFFFFFFFF_FFFFFFF0, 64'd2,
              64'h00000000_FFFFFFF0, 64'd2, 64'h00000000_7FFFFFF8, 64'h00000000_7FFFFFF8);
        tick;
        bus64.req_valid  = 1'b1;
        bus64.req_funct3 = 3'b000;
        bus64.req_word   = 1'b1;
        bus64.req_rs1    = 64'h12345678_7FFFFFFF;
        bus64.req_rs2    = 64'd2;
        bus64.req_rd     = 5'd21;
        @(negedge clk);
        tick;
        bus64.req_valid = 1'b0;
        tick;
        @(negedge clk);
        checks++;
        if (bus64.resp_valid !== 1'b1 || bus64.resp_data !== 64'hFFFFFFFF_FFFFFFFE || bus64.resp_rd !== 5'd21) begin
            failures++;
            $display("FAIL mulw: valid=%b data=%h rd=%0d, expected 1 fffffffffffffffe 21",
                     bus64.resp_valid, bus64.resp_data, bus64.resp_rd);
        end
        bus64.resp_ready = 1'b1;
        tick;
        bus64.resp_ready = 1'b0;
    endtask

    initial begin
        bus32.req_valid = 1'b0; bus32.req_funct3 = 3'b0; bus32.req_word = 1'b0;
        bus32.req_rs1 = '0; bus32.req_rs2 = '0; bus32.req_rd = '0;
        bus32.flush = 1'b0; bus32.resp_ready = 1'b0;
        bus64.req_valid = 1'b0; bus64.req_funct3 = 3'b0; bus64.req_word = 1'b0;
        bus64.req_rs1 = '0; bus64.req_rs2 = '0; bus64.req_rd = '0;
        bus64.flush = 1'b0; bus64.resp_ready = 1'b0;
        d32_res = '0; d32_busy = 1'b0; d32_rdy = 1'b0;
        d64_res = '0; d64_busy = 1'b0; d64_rdy = 1'b0;
        test_reset;
        test_mul;
        test_div;
        test_div_busy_hold;
        test_flush_issue;
        test_flush_drain;
        test_resp_hold;
        test_reset_mid_div;
        test_w_ops;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

M-extension sequencer sitting between the EX stage and the iterative divider. Accepts one MUL/DIV-family instruction at a time, computes multiplies internally with one registered product stage, and launches divides on the external `div_unit` with operands held stable for the whole operation. Presents a single registered result with rd tag to writeback under a valid/ready handshake, and handles pipeline flush including draining an in-flight divide.

## Interface
Parameters:
- XLEN, default `XLEN` (32 or 64), datapath width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  M-extension instruction present
- req_ready  out  1  request accepted this cycle (high only in IDLE)
- req_funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- req_word  in  1  W-suffix op (ignored when XLEN=32)
- req_rs1, req_rs2  in  XLEN  operands
- req_rd  in  5  destination tag
- flush  in  1  kill in-flight and not-yet-consumed operation
- busy  out  1  state != IDLE
- resp_valid  out  1  result available
- resp_ready  in  1  writeback consumes result
- resp_data  out  XLEN  result
- resp_rd  out  5  destination tag of result
- div_start  out  1  one-cycle launch to divider
- div_op  out  2  req_funct3[1:0] of divide op
- div_word  out  1  registered req_word
- div_dividend, div_divisor  out  XLEN  registered operands
- div_result  in  XLEN  divider result
- div_busy  in  1  divider not idle
- div_ready  in  1  divider result valid (1-cycle pulse)

## Operation
- States: IDLE, MUL, DIV_ISSUE, DIV_WAIT, DRAIN, RESP.
- IDLE: req_ready=1. On req_valid && !flush, register funct3, word, rd, and conditioned operands. funct3[2]=0 → MUL; else → DIV_ISSUE.
- Operand conditioning for W ops (XLEN=64): signed ops (MUL*, DIV, REM) sign-extend from bit 31; DIVU/REMU zero-extend from bit 31.
- MUL: form signed (XLEN+1)×(XLEN+1) product; operands sign- or zero-extended per op (MULHSU: rs1 signed, rs2 unsigned). MUL takes low XLEN bits; MULH/MULHSU/MULHU take bits [2·XLEN-1:XLEN]. Register into resp_data. → RESP.
- DIV_ISSUE: div_start=1 while !div_busy, then → DIV_WAIT. If div_busy, hold with div_start=0.
- DIV_WAIT: on div_ready, capture div_result into resp_data. → RESP.
- W ops: resp_data = sign-extension of bits [31:0], applied in this block regardless of the divider's own handling.
- div_dividend/div_divisor/div_op/div_word are driven from registers and stay stable from DIV_ISSUE until div_ready. The divider reads the dividend live for the REM-by-zero case.
- RESP: resp_valid=1. On resp_ready → IDLE.
- Flush:
  - MUL, DIV_ISSUE, RESP → IDLE, result discarded. In DIV_ISSUE, flush suppresses div_start that cycle.
  - DIV_WAIT → DRAIN. DRAIN waits for div_ready, discards the result, then → IDLE.
  - IDLE: the request is not accepted.
- Flush in the same cycle as resp_ready in RESP: the handshake completes and the result is delivered.
- Reset: state IDLE; all outputs 0 (req_ready=1 from the first cycle after reset). Reset mid-divide abandons the divider, which shares the reset domain.

## Timing
- Accept in cycle 0:
  - MUL family: resp_valid in cycle 2.
  - Divide with idle divider: div_start in cycle 1; div_ready arrives in cycle k; resp_valid in cycle k+1.
- resp_valid, resp_data and resp_rd hold stable until resp_ready or flush.
- At most one operation in flight. A new request can be accepted the cycle after the RESP handshake.
- div_start is never high for more than one cycle per operation, and never high while div_busy=1.

## Test plan
- MUL 7×(−3), XLEN=32 → resp_data 0xFFFFFFEB at cycle 2. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU −1×0xFFFFFFFF → 0xFFFFFFFF.
- DIV −20/3 → 0xFFFFFFFA; REM −20/3 → 0xFFFFFFFE; DIVU 20/0 → 0xFFFFFFFF; REM 20/0 → 20. Check exactly one div_start pulse per op and operands stable until div_ready.
- XLEN=64 DIVW 0x00000000_80000000 / −1 → 0xFFFFFFFF_80000000; DIVUW rs1 = 0xFFFFFFFF_FFFFFFF0, rs2 = 2 → 0x000000007FFFFFF8 sign-extended from bit 31 = 0x000000007FFFFFF8.
- Flush during DIV_WAIT, then req_valid asserted → req_ready stays 0 until the drained div_ready. The next DIV's result is correct and the stale result never appears on resp.
- Hold resp_ready=0 for 5 cycles → resp_valid, resp_data and resp_rd stable. Flush together with resp_ready → result delivered, then IDLE.
- Assert reset during DIV_WAIT → next cycle all outputs 0, req_ready=1, and a subsequent MUL completes normally.
